// File: rtl/dma_pkg.sv
// Shared definitions for the dma_bus_master block.
// Register indices, CTRL bit positions and FSM state encoding.
package dma_pkg;

  localparam logic [3:0] REG_SRC_L = 4'd0;
  localparam logic [3:0] REG_SRC_M = 4'd1;
  localparam logic [3:0] REG_SRC_H = 4'd2;
  localparam logic [3:0] REG_DST_L = 4'd3;
  localparam logic [3:0] REG_DST_M = 4'd4;
  localparam logic [3:0] REG_DST_H = 4'd5;
  localparam logic [3:0] REG_CNT_L = 4'd6;
  localparam logic [3:0] REG_CNT_H = 4'd7;
  localparam logic [3:0] REG_CTRL  = 4'd8;

  localparam int CTRL_START = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_ABORT = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_NXT  = 3'd5,
    S_REL  = 3'd6
  } state_t;

endpackage

// File: rtl/dma_bus_master_if.sv
// CPU register window plus system bus master signals.
// master = DMA engine side, slave = CPU/bus side.
interface dma_bus_master_if;
  logic        cs_n;
  logic        wr_n;
  logic        rd_n;
  logic [3:0]  a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        irq;
  logic        hold;
  logic        hlda;
  logic [19:0] m_addr;
  logic        m_rd_n;
  logic        m_wr_n;
  logic        m_iom;
  logic [7:0]  m_dout;
  logic [7:0]  m_din;

  modport master (
    input  cs_n, wr_n, rd_n, a, din, hlda, m_din,
    output dout, irq, hold, m_addr, m_rd_n, m_wr_n, m_iom, m_dout
  );

  modport slave (
    output cs_n, wr_n, rd_n, a, din, hlda, m_din,
    input  dout, irq, hold, m_addr, m_rd_n, m_wr_n, m_iom, m_dout
  );
endinterface

// File: rtl/dma_regs.sv
// CPU-visible register file, start/abort pulses, done/irq.
// SRC/DST/CNT double as live working counters while busy.
module dma_regs
  import dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs_n,
  input  logic        i_wr_n,
  input  logic        i_rd_n,
  input  logic [3:0]  i_a,
  input  logic [7:0]  i_din,
  input  logic        i_busy,
  input  logic        i_step,
  input  logic        i_set_done,
  input  logic        i_clr_done,
  output logic [7:0]  o_dout,
  output logic        o_irq,
  output logic [19:0] o_src,
  output logic [19:0] o_dst,
  output logic [15:0] o_cnt,
  output logic        o_start,
  output logic        o_abort
);

  logic [19:0] r_src;
  logic [19:0] r_dst;
  logic [15:0] r_cnt;
  logic        r_irq_en;
  logic        r_done;
  logic        r_abort;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_ctrl_rd;
  logic        w_cfg_wr;

  assign w_wr      = !i_cs_n && !i_wr_n;
  assign w_ctrl_wr = w_wr && (i_a == REG_CTRL);
  assign w_ctrl_rd = !i_cs_n && !i_rd_n && (i_a == REG_CTRL);
  assign w_cfg_wr  = w_wr && !i_busy;
  assign o_start   = w_ctrl_wr && i_din[CTRL_START];

  assign o_src   = r_src;
  assign o_dst   = r_dst;
  assign o_cnt   = r_cnt;
  assign o_abort = r_abort;
  assign o_irq   = r_done && r_irq_en;

  // Address/count registers: CPU load when idle, step when moving.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_src <= r_src + 20'd1;
      r_dst <= r_dst + 20'd1;
      r_cnt <= r_cnt - 16'd1;
    end else if (w_cfg_wr) begin
      case (i_a)
        REG_SRC_L: r_src[7:0]   <= i_din;
        REG_SRC_M: r_src[15:8]  <= i_din;
        REG_SRC_H: r_src[19:16] <= i_din[3:0];
        REG_DST_L: r_dst[7:0]   <= i_din;
        REG_DST_M: r_dst[15:8]  <= i_din;
        REG_DST_H: r_dst[19:16] <= i_din[3:0];
        REG_CNT_L: r_cnt[7:0]   <= i_din;
        REG_CNT_H: r_cnt[15:8]  <= i_din;
        default: ;
      endcase
    end
  end

  // Control flags: irq enable, done (set beats clear), abort latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      if (w_ctrl_wr)
        r_irq_en <= i_din[CTRL_IRQEN];
      if (i_set_done)
        r_done <= 1'b1;
      else if (i_clr_done || w_ctrl_rd)
        r_done <= 1'b0;
      if (!i_busy)
        r_abort <= 1'b0;
      else if (w_ctrl_wr && i_din[CTRL_ABORT])
        r_abort <= 1'b1;
    end
  end

  // Read mux, combinational from the index.
  always_comb begin
    o_dout = 8'h00;
    case (i_a)
      REG_SRC_L: o_dout = r_src[7:0];
      REG_SRC_M: o_dout = r_src[15:8];
      REG_SRC_H: o_dout = {4'h0, r_src[19:16]};
      REG_DST_L: o_dout = r_dst[7:0];
      REG_DST_M: o_dout = r_dst[15:8];
      REG_DST_H: o_dout = {4'h0, r_dst[19:16]};
      REG_CNT_L: o_dout = r_cnt[7:0];
      REG_CNT_H: o_dout = r_cnt[15:8];
      REG_CTRL:  o_dout = {5'b0, r_irq_en, r_done, i_busy};
      default:   o_dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/dma_bus_master.sv
// Memory-to-memory DMA engine borrowing the bus via HOLD/HLDA.
// Holds the transfer FSM, burst counter and data latch.
module dma_bus_master
  import dma_pkg::*;
#(
  parameter int RD_WAIT   = 1,
  parameter int BURST_LEN = 16
) (
  input logic             clk,
  input logic             rst,
  dma_bus_master_if.master bus
);

  localparam logic [3:0]  LP_RDW = 4'(RD_WAIT);
  localparam logic [15:0] LP_BL  = 16'(BURST_LEN);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait;
  logic [15:0] r_burst;
  logic        r_fin;
  logic [7:0]  r_data;
  logic [19:0] r_maddr;
  logic [19:0] w_maddr;
  logic [19:0] w_src;
  logic [19:0] w_dst;
  logic [15:0] w_cnt;
  logic        w_start;
  logic        w_abort;
  logic        w_busy;
  logic        w_step;
  logic        w_set_done;
  logic        w_clr_done;
  logic        w_fin_nx;
  logic        w_burst_clr;

  assign w_busy = (r_state != S_IDLE);

  dma_regs u_regs (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cs_n     (bus.cs_n),
    .i_wr_n     (bus.wr_n),
    .i_rd_n     (bus.rd_n),
    .i_a        (bus.a),
    .i_din      (bus.din),
    .i_busy     (w_busy),
    .i_step     (w_step),
    .i_set_done (w_set_done),
    .i_clr_done (w_clr_done),
    .o_dout     (bus.dout),
    .o_irq      (bus.irq),
    .o_src      (w_src),
    .o_dst      (w_dst),
    .o_cnt      (w_cnt),
    .o_start    (w_start),
    .o_abort    (w_abort)
  );

  // Next state and per-state control pulses.
  always_comb begin
    w_next      = r_state;
    w_step      = 1'b0;
    w_set_done  = 1'b0;
    w_clr_done  = 1'b0;
    w_fin_nx    = r_fin;
    w_burst_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_cnt != 16'd0) begin
            w_clr_done  = 1'b1;
            w_fin_nx    = 1'b0;
            w_burst_clr = 1'b1;
            w_next      = S_REQ;
          end else begin
            w_set_done = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (w_abort) begin
          w_fin_nx = 1'b1;
          w_next   = S_REL;
        end else if (bus.hlda) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        if (r_wait == LP_RDW)
          w_next = S_CAP;
      end
      S_CAP: w_next = S_WR;
      S_WR:  w_next = S_NXT;
      S_NXT: begin
        w_step = 1'b1;
        if (w_cnt == 16'd1 || w_abort) begin
          w_fin_nx    = 1'b1;
          w_burst_clr = 1'b1;
          w_next      = S_REL;
        end else if (BURST_LEN != 0 &&
                     r_burst + 16'd1 == LP_BL) begin
          w_burst_clr = 1'b1;
          w_next      = S_REL;
        end else begin
          w_next = S_RD;
        end
      end
      S_REL: begin
        if (!bus.hlda) begin
          if (r_fin) begin
            w_set_done = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus address: source in read phase, dest in write, else hold.
  always_comb begin
    w_maddr = r_maddr;
    if (r_state == S_RD || r_state == S_CAP)
      w_maddr = w_src;
    else if (r_state == S_WR)
      w_maddr = w_dst;
  end

  assign bus.hold   = (r_state == S_REQ) || (r_state == S_RD) ||
                      (r_state == S_CAP) || (r_state == S_WR) ||
                      (r_state == S_NXT);
  assign bus.m_rd_n = !(r_state == S_RD || r_state == S_CAP);
  assign bus.m_wr_n = !(r_state == S_WR);
  assign bus.m_iom  = 1'b0;
  assign bus.m_addr = w_maddr;
  assign bus.m_dout = r_data;

  // State register, read wait count, burst count and data latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_burst <= '0;
      r_fin   <= 1'b0;
      r_data  <= '0;
      r_maddr <= '0;
    end else begin
      r_state <= w_next;
      r_fin   <= w_fin_nx;
      r_maddr <= w_maddr;
      if (r_state == S_RD && w_next == S_RD)
        r_wait <= r_wait + 4'd1;
      else
        r_wait <= '0;
      if (w_burst_clr)
        r_burst <= '0;
      else if (w_step)
        r_burst <= r_burst + 16'd1;
      if (r_state == S_CAP)
        r_data <= bus.m_din;
    end
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed/randomized bench for dma_bus_master.
// Memory + HLDA responder model with copy-level reference checks.
module tb_dma_bus_master;
  import dma_pkg::*;

  localparam int RDW = 1;
  localparam int BL  = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dma_bus_master_if bus ();

  dma_bus_master #(.RD_WAIT(RDW), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0]  mem [0:1048575];
  logic [19:0] rd_log[$];
  logic [19:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];
  logic [7:0]  exp_q[$];
  int rises = 0, falls = 0, viol = 0, rd_starts = 0, hd = 0;
  logic prev_rd = 1'b1, prev_hold = 1'b0;

  assign bus.m_din = mem[bus.m_addr];

  // Bus monitor, memory write port and HLDA responder.
  always @(negedge clk) begin
    if (!bus.m_rd_n && !bus.m_wr_n) viol++;
    if (bus.m_iom !== 1'b0) viol++;
    if ((!bus.m_rd_n || !bus.m_wr_n) && bus.hlda !== 1'b1) viol++;
    if (!bus.m_rd_n && prev_rd) begin
      rd_log.push_back(bus.m_addr);
      rd_starts++;
    end
    if (!bus.m_wr_n) begin
      mem[bus.m_addr] = bus.m_dout;
      wr_a.push_back(bus.m_addr);
      wr_d.push_back(bus.m_dout);
      wr_c.push_back(cyc);
    end
    if (bus.hold && !prev_hold) rises++;
    if (!bus.hold && prev_hold) falls++;
    prev_rd   = bus.m_rd_n;
    prev_hold = bus.hold;
    if (rst) begin
      bus.hlda = 1'b0;
    end else if (bus.hold && bus.hlda !== 1'b1) begin
      if (hd == 0) begin
        bus.hlda = 1'b1;
        hd = $urandom_range(0, 3);
      end else begin
        hd--;
      end
    end else if (!bus.hold) begin
      bus.hlda = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    bus.a = a; bus.din = d; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    @(posedge clk); #1;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    bus.a = a; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    #1 d = bus.dout;
    @(posedge clk); #1;
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    bus.a = a;
    #1 d = bus.dout;
  endtask

  task automatic peek20(input logic [3:0] base, output logic [19:0] v);
    logic [7:0] b0, b1, b2;
    peek(base, b0);
    peek(base + 4'd1, b1);
    peek(base + 4'd2, b2);
    v = {b2[3:0], b1, b0};
  endtask

  task automatic clr_logs();
    rd_log.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    exp_q.delete();
    rises = 0; falls = 0; rd_starts = 0;
  endtask

  task automatic setup(input logic [19:0] s, input logic [19:0] d,
                       input int n);
    logic [15:0] n16;
    clr_logs();
    n16 = 16'(n);
    for (int i = 0; i < n; i++) begin
      logic [19:0] ad;
      logic [7:0]  v;
      ad = s + 20'(i);
      v = 8'($urandom);
      mem[ad] = v;
      exp_q.push_back(v);
    end
    wr_reg(REG_SRC_L, s[7:0]);
    wr_reg(REG_SRC_M, s[15:8]);
    wr_reg(REG_SRC_H, {4'h0, s[19:16]});
    wr_reg(REG_DST_L, d[7:0]);
    wr_reg(REG_DST_M, d[15:8]);
    wr_reg(REG_DST_H, {4'h0, d[19:16]});
    wr_reg(REG_CNT_L, n16[7:0]);
    wr_reg(REG_CNT_H, n16[15:8]);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] c;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      peek(REG_CTRL, c);
      if (!c[0]) begin ok = 1'b1; break; end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_copy(input string tag, input logic [19:0] d,
                          input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      if (wr_a[i] !== d + 20'(i)) bad++;
      if (wr_d[i] !== exp_q[i]) bad++;
    end
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(n));
    chk({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0]  c, c2;
    logic [19:0] s, d, v;
    int acc, bad, nw;

    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1;
    bus.a = 4'h0; bus.din = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", 32'(bus.hold), 32'd0);
    chk("rst_strobes", {30'd0, bus.m_rd_n, bus.m_wr_n}, 32'd3);
    chk("rst_maddr", 32'(bus.m_addr), 32'd0);
    chk("rst_mdout", 32'(bus.m_dout), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), c);
      acc = acc | int'(c);
    end
    chk("rst_regs", 32'(acc), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4-byte copy
    setup(20'h00100, 20'h00200, 4);
    wr_reg(REG_CTRL, 8'h01);
    wait_idle("t1");
    chk_copy("t1", 20'h00200, 4);
    chk("t1_rises", 32'(rises), 32'd1);
    chk("t1_irq_off", 32'(bus.irq), 32'd0);
    peek20(REG_SRC_L, v);
    chk("t1_src_end", 32'(v), 32'h00104);
    rd_reg(REG_CTRL, c);
    chk("t1_ctrl1", 32'(c), 32'h02);
    rd_reg(REG_CTRL, c);
    chk("t1_ctrl2", 32'(c), 32'h00);

    // 40 bytes in bursts of 16
    s = 20'h10000 + 20'($urandom_range(0, 20'h2FFFF));
    d = s + 20'h40000;
    setup(s, d, 40);
    wr_reg(REG_CTRL, 8'h01);
    wr_reg(REG_SRC_L, 8'hAA);
    wr_reg(REG_CTRL, 8'h01);
    wait_idle("t2");
    chk_copy("t2", d, 40);
    chk("t2_rises", 32'(rises), 32'd3);
    chk("t2_falls", 32'(falls), 32'd3);
    peek20(REG_SRC_L, v);
    chk("t2_src_end", 32'(v), 32'(s + 20'd40));
    bad = 0;
    for (int i = 0; i + 1 < wr_c.size(); i++)
      if ((i + 1) % BL != 0 && wr_c[i+1] - wr_c[i] != RDW + 4) bad++;
    chk("t2_rate", 32'(bad), 32'd0);
    rd_reg(REG_CTRL, c);

    // Source address wrap at 1 MiB
    d = 20'h50000 + 20'($urandom_range(0, 20'h0FFFF));
    setup(20'hFFFFE, d, 4);
    wr_reg(REG_CTRL, 8'h01);
    wait_idle("t3");
    chk_copy("t3", d, 4);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= rd_log.size() || rd_log[i] !== 20'hFFFFE + 20'(i)) bad++;
    chk("t3_rd_addr", 32'(bad), 32'd0);
    chk("t3_nrd", 32'(rd_log.size()), 32'd4);
    rd_reg(REG_CTRL, c);

    // Zero count with irq enabled
    clr_logs();
    wr_reg(REG_CNT_L, 8'h00);
    wr_reg(REG_CNT_H, 8'h00);
    wr_reg(REG_CTRL, 8'h03);
    peek(REG_CTRL, c);
    chk("t4_ctrl", 32'(c), 32'h06);
    chk("t4_irq", 32'(bus.irq), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_irq_hold", 32'(bus.irq), 32'd1);
    chk("t4_no_hold", 32'(rises), 32'd0);
    rd_reg(REG_CTRL, c);
    chk("t4_rd", 32'(c), 32'h06);
    chk("t4_irq_clr", 32'(bus.irq), 32'd0);
    peek(REG_CTRL, c2);
    chk("t4_ctrl_after", 32'(c2), 32'h04);

    // Abort during third byte read
    s = 20'h60000 + 20'($urandom_range(0, 20'h0FFFF));
    d = s + 20'h20000;
    setup(s, d, 10);
    wr_reg(REG_CTRL, 8'h01);
    for (int i = 0; i < 3000 && rd_starts < 3; i++) begin
      @(negedge clk); #2;
    end
    chk("t5_reach", 32'(rd_starts), 32'd3);
    wr_reg(REG_CTRL, 8'h04);
    wait_idle("t5");
    chk_copy("t5", d, 3);
    chk("t5_hold", 32'(bus.hold), 32'd0);
    peek(REG_CNT_L, c);
    peek(REG_CNT_H, c2);
    chk("t5_cnt", {16'd0, c2, c}, 32'd7);
    peek(REG_CTRL, c);
    chk("t5_done", 32'(c), 32'h02);
    rd_reg(REG_CTRL, c);

    // Reset in the middle of a write
    s = 20'h80000 + 20'($urandom_range(0, 20'h0FFFF));
    setup(s, s + 20'h10000, 8);
    wr_reg(REG_CTRL, 8'h01);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if (wr_a.size() >= 2 && bus.m_wr_n === 1'b0) break;
    end
    chk("t6_in_wr", 32'(bus.m_wr_n), 32'd0);
    nw = wr_a.size();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_hold", 32'(bus.hold), 32'd0);
    chk("t6_wr_n", 32'(bus.m_wr_n), 32'd1);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), c);
      acc = acc | int'(c);
    end
    chk("t6_regs", 32'(acc), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_wr", 32'(wr_a.size()), 32'(nw));
    chk("t6_idle_hold", 32'(bus.hold), 32'd0);

    chk("bus_viol", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
